sigmoid_sched: RTL

SIGMOID_SCHED -- requirements
Module: sigmoid_sched

---
 rtl/sigmoid_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sigmoid_sched.sv
// Round-robin scheduler sharing one fixed-latency sigmoid unit among NUM_REQ
// requesters, with credit-limited per-lane result FIFOs.

module sigmoid_lane #(
    parameter int OUT_W     = 8,
    parameter int RES_DEPTH = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             acc,
    input  logic                             wr,
    input  logic                             pop,
    input  logic [OUT_W-1:0]                 wr_data,
    output logic [$clog2(RES_DEPTH+1)-1:0]   credit,
    output logic                             full,
    output logic                             valid,
    output logic [OUT_W-1:0]                 data
);
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    logic [OUT_W-1:0] mem [RES_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit covers ops still in the sigmoid plus ops sitting in the FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            credit <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: ;
            endcase
            if (wr) wr_ptr <= bump(wr_ptr);
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    assign valid = (count != '0);
    assign full  = (count == CW'(RES_DEPTH));
    assign data  = valid ? mem[rd_ptr] : '0;
endmodule

module sigmoid_sched #(
    parameter int NUM_REQ   = 4,
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int SIG_LAT   = 5,
    parameter int RES_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IN_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IN_W-1:0]            sig_in_data,
    input  logic [OUT_W-1:0]           sig_out_data,
    output logic [NUM_REQ-1:0]         res_valid,
    output logic [NUM_REQ*OUT_W-1:0]   res_data,
    input  logic [NUM_REQ-1:0]         res_ready,
    output logic                       busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);

    logic [IW-1:0]                     rr_ptr;
    logic [IW-1:0]                     gid;
    logic                              found;
    logic                              any_acc;
    logic [NUM_REQ-1:0]                elig;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_REQ-1:0]                accept;
    logic [NUM_REQ-1:0]                pop_vec;
    logic [NUM_REQ-1:0]                push_vec;
    logic [NUM_REQ-1:0]                full_vec;
    logic [NUM_REQ-1:0]                wr_vec;
    logic [NUM_REQ-1:0][CW-1:0]        credit;
    logic [NUM_REQ-1:0][IN_W-1:0]      req_arr;
    // Stage 0 travels alongside sig_in_data; stage SIG_LAT lines up with sig_out_data.
    logic [SIG_LAT:0]                  vld_pipe;
    logic [SIG_LAT:0][IW-1:0]          id_pipe;

    assign req_arr = req_data;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = req_valid[i] && (credit[i] < CW'(RES_DEPTH));
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gid   = '0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gid   = IW'(idx);
            end
        end
        if (found && reset) grant[gid] = 1'b1;
    end

    assign req_ready = grant;
    assign accept    = req_valid & req_ready;
    assign any_acc   = |accept;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr      <= '0;
            sig_in_data <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
        end else begin
            if (any_acc) rr_ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + IW'(1);
            sig_in_data <= any_acc ? req_arr[gid] : '0;
            vld_pipe    <= {vld_pipe[SIG_LAT-1:0], any_acc};
            id_pipe     <= {id_pipe[SIG_LAT-1:0], gid};
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            push_vec[i] = vld_pipe[SIG_LAT] && (id_pipe[SIG_LAT] == IW'(i));
    end

    assign pop_vec = res_valid & res_ready;
    assign wr_vec  = push_vec & (~full_vec | pop_vec);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        sigmoid_lane #(
            .OUT_W    (OUT_W),
            .RES_DEPTH(RES_DEPTH)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .acc    (accept[i]),
            .wr     (wr_vec[i]),
            .pop    (pop_vec[i]),
            .wr_data(sig_out_data),
            .credit (credit[i]),
            .full   (full_vec[i]),
            .valid  (res_valid[i]),
            .data   (res_data[i*OUT_W +: OUT_W])
        );
    end

    assign busy = (|vld_pipe) || (|res_valid);
endmodule
